// File: rtl/uart_tx.sv
// uart_tx: UART serializer feeding the UART receiver's RX_IN.
//
// Accepts parallel words through a valid/ready handshake into a 1-deep
// holding buffer. Frames go out LSB-first: start bit, DATA_WIDTH data
// bits, an optional parity bit and a stop bit. Every bit is held for the
// Prescale value latched when the frame starts (values below 2 are
// treated as 2).
//
// Ports:
//   CLK        system clock
//   RST        synchronous, active-high reset
//   P_DATA     word to transmit
//   Data_Valid P_DATA valid; taken on a rising CLK edge while ready=1
//   PAR_EN     1 = append parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   Prescale   CLK cycles per bit (8, 16 or 32 in normal use)
//   TX_OUT     serial line, idles high
//   ready      holding buffer empty, a word can be accepted
//   busy       frame in progress (START through the last STOP cycle)
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  ready,
    output logic                  busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q,     state_d;
    logic [DATA_WIDTH-1:0]  shift_q,     shift_d;
    logic [DATA_WIDTH-1:0]  buf_q,       buf_d;
    logic                   buf_full_q,  buf_full_d;
    logic [5:0]             prescale_q,  prescale_d;
    logic                   par_en_q,    par_en_d;
    logic                   par_bit_q,   par_bit_d;
    logic [5:0]             presc_cnt_q, presc_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic                   tx_q,        tx_d;
    logic                   busy_q,      busy_d;

    logic                   accept;
    logic                   bit_end;
    logic                   load_frame;
    logic [DATA_WIDTH-1:0]  load_word;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [5:0]             prescale_eff;

    assign accept       = Data_Valid & ~buf_full_q;
    assign bit_end      = (presc_cnt_q == (prescale_q - 6'd1));
    assign shifted      = shift_q >> 1;
    assign prescale_eff = (Prescale < 6'd2) ? 6'd2 : Prescale;

    // Next-state logic. A frame start (load_frame) can come from IDLE or
    // straight out of STOP when the buffer is full; in both cases the
    // configuration inputs are sampled here and held for the whole frame.
    // The parity bit is computed from the word at load time so that later
    // PAR_TYP changes cannot affect the frame in flight.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        prescale_d  = prescale_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        presc_cnt_d = presc_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        load_frame  = 1'b0;
        load_word   = P_DATA;

        // Outside IDLE an accepted word always lands in the buffer.
        if (accept && (state_q != S_IDLE)) begin
            buf_d      = P_DATA;
            buf_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                presc_cnt_d = 6'd0;
                // A word left in the buffer at the end of the previous
                // frame takes priority; ready is low then, so Data_Valid
                // cannot be accepted at the same time.
                if (buf_full_q) begin
                    load_frame = 1'b1;
                    load_word  = buf_q;
                    buf_full_d = 1'b0;
                end else if (Data_Valid) begin
                    load_frame = 1'b1;
                    load_word  = P_DATA;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d     = S_DATA;
                    presc_cnt_d = 6'd0;
                    bit_cnt_d   = '0;
                    tx_d        = shift_q[0];
                end else begin
                    presc_cnt_d = presc_cnt_q + 6'd1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    presc_cnt_d = 6'd0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shifted;
                        tx_d      = shifted[0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 6'd1;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d     = S_STOP;
                    presc_cnt_d = 6'd0;
                    tx_d        = 1'b1;
                end else begin
                    presc_cnt_d = presc_cnt_q + 6'd1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    presc_cnt_d = 6'd0;
                    // Buffered word chains in with no idle gap.
                    if (buf_full_q) begin
                        load_frame = 1'b1;
                        load_word  = buf_q;
                        buf_full_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 6'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load_frame) begin
            state_d     = S_START;
            shift_d     = load_word;
            par_bit_d   = PAR_TYP ? ~^load_word : ^load_word;
            prescale_d  = prescale_eff;
            par_en_d    = PAR_EN;
            presc_cnt_d = 6'd0;
            bit_cnt_d   = '0;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
        end
    end

    // State register. Reset aborts any frame and drops the buffered word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            prescale_q  <= 6'd0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            presc_cnt_q <= 6'd0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            prescale_q  <= prescale_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            presc_cnt_q <= presc_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;
    assign ready  = ~buf_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed testbench for uart_tx (DATA_WIDTH = 8).
// Stimulus is driven #1 after a rising edge and outputs are sampled at the
// same point, so every check sees settled register values.
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       ready;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .ready      (ready),
        .busy       (busy)
    );

    // 100 MHz clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net in case something stalls beyond every local bound.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Offer a word and hold Data_Valid until an edge where ready was high.
    // Returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [7:0] data);
        logic wasReady;
        logic done;
        done       = 1'b0;
        P_DATA     = data;
        Data_Valid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            wasReady = ready;
            tick(1);
            if (wasReady) done = 1'b1;
        end
        Data_Valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    // Called #1 after the edge that entered START. Checks each bit at its
    // first and last cycle (exact timing) and busy throughout; returns #1
    // after the edge that ends the stop bit.
    task automatic checkFrame(input string tag, input logic [7:0] data,
                              input logic parEn, input logic expPar, input int p);
        logic bits [0:10];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (parEn) begin
            bits[n] = expPar;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_bit%0d_first", tag, k), 32'(TX_OUT), 32'(bits[k]));
            checkOutput($sformatf("%s_bit%0d_busy", tag, k), 32'(busy), 32'd1);
            tick(p - 1);
            checkOutput($sformatf("%s_bit%0d_last", tag, k), 32'(TX_OUT), 32'(bits[k]));
            tick(1);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_tx"}, 32'(TX_OUT), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [7:0] rxData;
        logic       rxPar;
        logic       rxStop;
        logic       sawLow;

        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        tick(3);
        RST = 1'b0;
        checkIdle("reset");

        // Test 1: odd parity, 32 cycles/bit, 0xBB -> parity 1
        $display("[TB] test 1: 0xBB odd parity P=32");
        PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd32;
        applyStimulus(8'hBB);
        checkFrame("t1", 8'hBB, 1'b1, 1'b1, 32);
        checkIdle("t1_end");

        // Test 2: even parity, 16 cycles/bit, 0x8D -> parity 0
        $display("[TB] test 2: 0x8D even parity P=16");
        PAR_TYP = 1'b0; Prescale = 6'd16;
        applyStimulus(8'h8D);
        checkFrame("t2", 8'h8D, 1'b1, 1'b0, 16);
        checkIdle("t2_end");

        // Test 3: back-to-back through the buffer, no parity, P=8
        $display("[TB] test 3: 0x9F then buffered 0x12");
        PAR_EN = 1'b0; Prescale = 6'd8;
        applyStimulus(8'h9F);
        fork
            begin
                checkFrame("t3a", 8'h9F, 1'b0, 1'b0, 8);
                checkOutput("t3_readyAfterFirst", 32'(ready), 32'd1);
                checkFrame("t3b", 8'h12, 1'b0, 1'b0, 8);
            end
            begin
                tick(3);
                P_DATA = 8'h12; Data_Valid = 1'b1;
                tick(1);
                Data_Valid = 1'b0;
                checkOutput("t3_readyBuffered", 32'(ready), 32'd0);
                tick(6);
                // Offered while ready=0: must be ignored.
                P_DATA = 8'h55; Data_Valid = 1'b1;
                tick(10);
                Data_Valid = 1'b0;
                tick(59);
                checkOutput("t3_readyLate", 32'(ready), 32'd0);
            end
        join
        checkIdle("t3_end");

        // Test 4: config changes mid-frame affect only the next frame
        $display("[TB] test 4: 0xAB P=32 parity, then 0x3C P=8 no parity");
        PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd32;
        applyStimulus(8'hAB);
        fork
            begin
                checkFrame("t4a", 8'hAB, 1'b1, 1'b1, 32);
                checkFrame("t4b", 8'h3C, 1'b0, 1'b0, 8);
            end
            begin
                tick(50);
                Prescale = 6'd8; PAR_EN = 1'b0;
                P_DATA = 8'h3C; Data_Valid = 1'b1;
                tick(1);
                Data_Valid = 1'b0;
                checkOutput("t4_readyBuffered", 32'(ready), 32'd0);
            end
        join
        checkIdle("t4_end");

        // Prescale below 2 is treated as 2
        $display("[TB] clamp: Prescale=1 sends with 2-cycle bits");
        Prescale = 6'd1;
        applyStimulus(8'hF0);
        checkFrame("clamp", 8'hF0, 1'b0, 1'b0, 2);
        checkIdle("clamp_end");

        // Test 5: reset mid-DATA with a word buffered
        $display("[TB] test 5: reset mid-frame");
        Prescale = 6'd8;
        applyStimulus(8'h5A);
        P_DATA = 8'h66; Data_Valid = 1'b1;
        tick(1);
        Data_Valid = 1'b0;
        checkOutput("t5_readyBuffered", 32'(ready), 32'd0);
        tick(18);
        checkOutput("t5_busyBeforeRst", 32'(busy), 32'd1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        checkIdle("t5_afterRst");
        sawLow = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (TX_OUT !== 1'b1 || busy !== 1'b0) sawLow = 1'b1;
        end
        checkOutput("t5_noResume", 32'(sawLow), 32'd0);

        // Test 6: mid-bit sampling as the receiver would, odd parity, P=8
        $display("[TB] test 6: receiver-style decode of 0xC2");
        PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd8;
        applyStimulus(8'hC2);
        tick(4);
        checkOutput("t6_rxStart", 32'(TX_OUT), 32'd0);
        rxData = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick(8);
            rxData[i] = TX_OUT;
        end
        tick(8);
        rxPar = TX_OUT;
        tick(8);
        rxStop = TX_OUT;
        checkOutput("t6_rxData", 32'(rxData), 32'h0000_00C2);
        checkOutput("t6_rxParity", 32'(rxPar), 32'd0);
        checkOutput("t6_rxStop", 32'(rxStop), 32'd1);
        tick(4);
        checkIdle("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
